// File: rtl/matmul_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply host loader.
package matmul_pkg;

    localparam int unsigned DWIDTH        = 8;
    localparam int unsigned MAT_SIZE      = 32;
    localparam int unsigned AWIDTH        = 7;
    localparam int unsigned HOST_W        = 32;
    localparam int unsigned ROW_W         = MAT_SIZE * DWIDTH;
    localparam int unsigned BEATS_PER_ROW = ROW_W / HOST_W;
    localparam int unsigned BEAT_W        = $clog2(BEATS_PER_ROW);
    localparam int unsigned ROW_CNT_W     = $clog2(MAT_SIZE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_DRAIN  = 3'd3,
        S_RUN    = 3'd4,
        S_FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/row_packer.sv
// Packs HOST_W-wide host beats into ROW_W-wide rows, first beat in the LSBs.
module row_packer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic              i_ready,
    input  logic [HOST_W-1:0] i_data,
    output logic              o_row_done,
    output logic              o_row_valid,
    output logic [ROW_W-1:0]  o_row_data
);

    logic [BEAT_W-1:0] r_beat;
    logic [ROW_W-1:0]  r_pack;
    logic              r_row_valid;
    logic              w_accept;

    assign w_accept    = i_valid & i_ready;
    // High in the cycle whose accepting edge lands the final beat of a row.
    assign o_row_done  = w_accept && (r_beat == BEAT_W'(BEATS_PER_ROW - 1));
    assign o_row_valid = r_row_valid;
    assign o_row_data  = r_pack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat      <= '0;
            r_pack      <= '0;
            r_row_valid <= 1'b0;
        end else begin
            r_row_valid <= o_row_done;
            if (i_clear) begin
                r_beat <= '0;
            end else if (w_accept) begin
                r_pack[r_beat*HOST_W +: HOST_W] <= i_data;
                r_beat <= o_row_done ? '0 : r_beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_load_ctrl.sv
// Host loader: fills matrix A then B RAM row by row, then runs the multiply.
module matmul_load_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned WE_DELAY    = 2,
    parameter int unsigned RUN_TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HOST_W-1:0] in_data,
    output logic              enable_writing_to_mem,
    output logic [AWIDTH-1:0] addr_pi,
    output logic [ROW_W-1:0]  data_pi,
    output logic              we_a,
    output logic              we_b,
    output logic              start_mat_mul,
    input  logic              done_mat_mul,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned RUN_CW = $clog2(RUN_TIMEOUT + 1);

    state_t               r_state;
    state_t               w_next;
    logic [ROW_CNT_W-1:0] r_row_cnt;
    logic [AWIDTH-1:0]    r_addr;
    logic [RUN_CW-1:0]    r_run_cnt;
    logic                 r_error;
    logic                 r_row_a;
    logic                 r_row_b;
    logic [ROW_W-1:0]     r_dl_data [WE_DELAY];
    logic [WE_DELAY-1:0]  r_dl_v;
    logic [WE_DELAY-1:0]  r_dl_a;
    logic [WE_DELAY-1:0]  r_dl_b;

    logic                 w_loading;
    logic                 w_start;
    logic                 w_row_done;
    logic                 w_row_valid;
    logic [ROW_W-1:0]     w_row_data;
    logic                 w_last_row;
    logic                 w_pipe_busy;
    logic                 w_timeout;
    logic                 w_set_error;

    row_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start),
        .i_valid     (in_valid),
        .i_ready     (w_loading),
        .i_data      (in_data),
        .o_row_done  (w_row_done),
        .o_row_valid (w_row_valid),
        .o_row_data  (w_row_data)
    );

    assign w_loading   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign w_start     = (r_state == S_IDLE) && cmd_start;
    assign w_last_row  = (r_row_cnt == ROW_CNT_W'(MAT_SIZE - 1));
    assign w_pipe_busy = w_row_valid | (|r_dl_v);
    assign w_timeout   = (r_run_cnt == RUN_CW'(RUN_TIMEOUT - 1));

    assign in_ready = w_loading;
    assign addr_pi  = r_addr;
    assign data_pi  = r_dl_data[WE_DELAY-1];
    assign we_a     = r_dl_v[WE_DELAY-1] & r_dl_a[WE_DELAY-1];
    assign we_b     = r_dl_v[WE_DELAY-1] & r_dl_b[WE_DELAY-1];
    assign error    = r_error;

    always_comb begin
        w_next                = r_state;
        enable_writing_to_mem = 1'b0;
        start_mat_mul         = 1'b0;
        busy                  = 1'b1;
        done                  = 1'b0;
        w_set_error           = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (cmd_start) w_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                enable_writing_to_mem = 1'b1;
                if (w_row_done && w_last_row) w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                enable_writing_to_mem = 1'b1;
                if (w_row_done && w_last_row) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Leaves one cycle after the final write pulse has left the delay line.
                enable_writing_to_mem = 1'b1;
                if (!w_pipe_busy) w_next = S_RUN;
            end
            S_RUN: begin
                start_mat_mul = 1'b1;
                if (done_mat_mul) begin
                    w_next = S_FINISH;
                end else if (w_timeout) begin
                    w_next      = S_FINISH;
                    w_set_error = 1'b1;
                end
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            r_addr    <= '0;
            r_run_cnt <= '0;
            r_error   <= 1'b0;
            r_row_a   <= 1'b0;
            r_row_b   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_row_cnt <= '0;
            end else if (w_row_done) begin
                r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
            end
            if (w_row_done) r_addr <= AWIDTH'(r_row_cnt);
            r_row_a   <= w_row_done && (r_state == S_LOAD_A);
            r_row_b   <= w_row_done && (r_state == S_LOAD_B);
            r_run_cnt <= (r_state == S_RUN) ? r_run_cnt + 1'b1 : '0;
            if (w_start) begin
                r_error <= 1'b0;
            end else if (w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    // Write-enable/data skew: addr_pi leads by one cycle, this line adds WE_DELAY more.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_v <= '0;
            r_dl_a <= '0;
            r_dl_b <= '0;
            for (int unsigned i = 0; i < WE_DELAY; i++) r_dl_data[i] <= '0;
        end else begin
            r_dl_v[0]    <= w_row_valid;
            r_dl_a[0]    <= r_row_a;
            r_dl_b[0]    <= r_row_b;
            r_dl_data[0] <= w_row_data;
            for (int unsigned i = 1; i < WE_DELAY; i++) begin
                r_dl_v[i]    <= r_dl_v[i-1];
                r_dl_a[i]    <= r_dl_a[i-1];
                r_dl_b[i]    <= r_dl_b[i-1];
                r_dl_data[i] <= r_dl_data[i-1];
            end
        end
    end

endmodule

// File: tb/tb_matmul_load_ctrl.sv
// Directed bench for matmul_load_ctrl: loads, skew, drain, run, timeout and reset.
module tb_matmul_load_ctrl;

    localparam int RUN_TO = 100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         enable_writing_to_mem;
    logic [6:0]   addr_pi;
    logic [255:0] data_pi;
    logic         we_a;
    logic         we_b;
    logic         start_mat_mul;
    logic         done_mat_mul = 1'b0;
    logic         busy;
    logic         done;
    logic         error;

    typedef struct {
        int           cyc;
        bit           a;
        int           addr;
        logic [255:0] data;
    } wr_t;

    typedef struct {
        int cyc;
        int addr;
    } ad_t;

    wr_t          exp_q[$];
    ad_t          addr_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           n_wr = 0;
    int           a31_cyc = 0;
    int           b0_cyc = 0;
    logic [255:0] a0_data = '0;
    logic [255:0] ram_a [32];
    logic [255:0] ram_b [32];
    logic [255:0] gold_a [32];
    logic [255:0] gold_b [32];

    matmul_load_ctrl #(
        .WE_DELAY    (2),
        .RUN_TIMEOUT (RUN_TO)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmd_start             (cmd_start),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_data               (in_data),
        .enable_writing_to_mem (enable_writing_to_mem),
        .addr_pi               (addr_pi),
        .data_pi               (data_pi),
        .we_a                  (we_a),
        .we_b                  (we_b),
        .start_mat_mul         (start_mat_mul),
        .done_mat_mul          (done_mat_mul),
        .busy                  (busy),
        .done                  (done),
        .error                 (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_i(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Write monitor: every pulse must match the next row the driver completed.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (addr_q.size() > 0 && addr_q[0].cyc == cyc) begin
                chk_i("addr_lead", int'(addr_pi), addr_q[0].addr);
                void'(addr_q.pop_front());
            end
            if (we_a === 1'b1 || we_b === 1'b1) begin
                n_wr++;
                chk_i("we_excl", int'(we_a && we_b), 0);
                chk_i("we_phase", int'({busy, start_mat_mul}), 2);
                chk_i("we_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk_i("we_cyc", cyc, e.cyc);
                    chk_i("we_sel", int'({we_a, we_b}), int'({e.a, !e.a}));
                    chk_i("we_addr", int'(addr_pi), e.addr);
                    chk_w("we_data", data_pi, e.data);
                end
                if (we_a) ram_a[addr_pi[4:0]] = data_pi;
                else      ram_b[addr_pi[4:0]] = data_pi;
                if (we_a && addr_pi == 7'd0)  a0_data = data_pi;
                if (we_a && addr_pi == 7'd31) a31_cyc = cyc;
                if (we_b && addr_pi == 7'd0)  b0_cyc  = cyc;
            end
        end
    end

    task automatic run_job(input bit bursty, input int n_beats, input bit pulse_b,
                           input bit pulse_run, input int done_after);
        logic [255:0] rowbuf = '0;
        int beat = 0;
        int guard = 0;
        int t_last = 0;
        int t_run = 0;
        int wr0 = n_wr;
        int exp_off;
        bit got = 0;
        bit fin = 0;
        wr_t e;
        ad_t ad;

        @(posedge clk); #1 cmd_start = 1'b1;
        @(posedge clk); #1 cmd_start = 1'b0;
        @(negedge clk);
        chk_i("start_busy", int'(busy), 1);
        chk_i("start_err_clr", int'(error), 0);
        chk_i("start_ready", int'(in_ready), 1);

        while (beat < n_beats && guard < 4000) begin
            @(posedge clk); #1;
            in_valid  = bursty ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data   = 32'(beat);
            cmd_start = pulse_b && (beat == 300);
            @(negedge clk);
            guard++;
            if (in_valid && in_ready) begin
                rowbuf[(beat % 8) * 32 +: 32] = 32'(beat);
                if (beat % 8 == 7) begin
                    e.cyc  = cyc + 3;
                    e.a    = (beat < 256);
                    e.addr = (beat / 8) % 32;
                    e.data = rowbuf;
                    exp_q.push_back(e);
                    ad.cyc  = cyc + 1;
                    ad.addr = (beat / 8) % 32;
                    addr_q.push_back(ad);
                    t_last = cyc;
                end
                beat++;
            end
        end
        chk_i("beats_accepted", beat, n_beats);
        if (n_beats < 512) return;

        @(posedge clk); #1 in_valid = 1'b0; cmd_start = 1'b0;
        @(negedge clk);
        chk_i("drain_ready", int'(in_ready), 0);
        chk_i("drain_wr_en", int'(enable_writing_to_mem), 1);
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            if (cyc == t_last + 4) chk_i("drain_wr_en_hold", int'(enable_writing_to_mem), 1);
            if (start_mat_mul === 1'b1) got = 1;
        end
        chk_i("run_entry", cyc - t_last, 5);
        chk_i("run_wr_en", int'(enable_writing_to_mem), 0);
        t_run = cyc;

        while (!fin && cyc < t_run + 300) begin
            @(posedge clk); #1;
            done_mat_mul = (done_after >= 0) && (cyc == t_run + done_after);
            cmd_start    = pulse_run && (cyc == t_run + 10);
            @(negedge clk);
            if (done === 1'b1) fin = 1;
        end
        exp_off = (done_after >= 0) ? done_after + 1 : RUN_TO;
        chk_i("finish_cyc", cyc - t_run, exp_off);
        chk_i("finish_err", int'(error), int'(done_after < 0));
        chk_i("finish_start", int'(start_mat_mul), 0);

        @(posedge clk); #1 done_mat_mul = 1'b0; cmd_start = 1'b0;
        @(negedge clk);
        chk_i("idle_busy", int'(busy), 0);
        chk_i("idle_done", int'(done), 0);
        chk_i("idle_err_sticky", int'(error), int'(done_after < 0));
        chk_i("job_writes", n_wr - wr0, 64);
        chk_i("exp_q_empty", exp_q.size(), 0);
        chk_i("addr_q_empty", addr_q.size(), 0);
    endtask

    initial begin
        int mism;
        int wr_before;

        for (int r = 0; r < 32; r++) begin
            ram_a[r] = '0;
            ram_b[r] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_i("reset_outputs", int'({in_ready, enable_writing_to_mem, addr_pi, we_a, we_b,
                                     start_mat_mul, busy, done, error}), 0);
        chk_w("reset_data", data_pi, '0);

        // Clean job, continuous host, multiply completes after 50 RUN cycles.
        run_job(1'b0, 512, 1'b0, 1'b0, 50);
        chk_w("a0_beat0", {224'd0, a0_data[31:0]}, 256'd0);
        chk_w("a0_beat1", {224'd0, a0_data[63:32]}, 256'd1);
        chk_w("a0_beat7", {224'd0, a0_data[255:224]}, 256'd7);
        chk_i("a_to_b_gap", b0_cyc - a31_cyc, 8);
        for (int r = 0; r < 32; r++) begin
            gold_a[r] = ram_a[r];
            gold_b[r] = ram_b[r];
            ram_a[r]  = '0;
            ram_b[r]  = '0;
        end

        // Bursty host must leave identical RAM contents.
        run_job(1'b1, 512, 1'b0, 1'b0, 50);
        mism = 0;
        for (int r = 0; r < 32; r++) begin
            if (ram_a[r] !== gold_a[r]) mism++;
            if (ram_b[r] !== gold_b[r]) mism++;
        end
        chk_i("bursty_ram", mism, 0);

        // Reset after three beats of A row 5: rows 0..4 written, row 5 discarded.
        wr_before = n_wr;
        run_job(1'b0, 43, 1'b0, 1'b0, 50);
        @(posedge clk); #1 reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_i("rst_mid_outputs", int'({in_ready, enable_writing_to_mem, addr_pi, we_a, we_b,
                                       start_mat_mul, busy, done, error}), 0);
        chk_w("rst_mid_data", data_pi, '0);
        chk_i("rst_mid_pending", exp_q.size(), 0);
        addr_q.delete();
        repeat (6) @(negedge clk);
        chk_i("rst_mid_writes", n_wr - wr_before, 5);
        run_job(1'b0, 512, 1'b0, 1'b0, 50);

        // cmd_start during LOAD_B and during RUN is ignored.
        run_job(1'b0, 512, 1'b1, 1'b1, 50);
        repeat (2) @(negedge clk);
        chk_i("ignored_start_idle", int'(busy), 0);

        // Withheld done_mat_mul: timeout, sticky error, cleared by next cmd_start.
        run_job(1'b0, 512, 1'b0, 1'b0, -1);
        run_job(1'b0, 512, 1'b0, 1'b0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/matmul_load_ctrl.md
Name: matmul_load_ctrl

Overview:
- Host-side loader that sits directly upstream of matrix_multiplication.
- Accepts a narrow valid/ready stream of int8 matrix data and packs it into 256-bit rows.
- Writes 32 rows into matrix A RAM, then 32 rows into matrix B RAM, with the address-to-write-enable skew the memory wrapper requires.
- Then drives start_mat_mul until done_mat_mul and reports completion.

Parameters:
- DWIDTH, 8, element width in bits
- MAT_SIZE, 32, rows per matrix and elements per row (row width = MAT_SIZE*DWIDTH = 256)
- AWIDTH, 7, memory address width
- HOST_W, 32, host beat width; BEATS_PER_ROW = MAT_SIZE*DWIDTH/HOST_W = 8
- WE_DELAY, 2, cycles by which data_pi/we_* must lag addr_pi (addr is double-registered downstream)
- RUN_TIMEOUT, 4095, max cycles in RUN before error

Ports:
- clk  in  1  single clock; also drives clk and clk_mem of the downstream block
- reset  in  1  synchronous, active-high
- cmd_start  in  1  one-cycle pulse; begins a load+multiply job
- in_valid  in  1  host beat valid
- in_ready  out  1  host beat accepted when in_valid && in_ready
- in_data  in  HOST_W  host beat; first beat of a row occupies the least-significant bits
- enable_writing_to_mem  out  1  address-mux select toward addr_pi
- addr_pi  out  AWIDTH  row address
- data_pi  out  MAT_SIZE*DWIDTH  packed row
- we_a  out  1  matrix A write enable
- we_b  out  1  matrix B write enable
- start_mat_mul  out  1  held high during multiply
- done_mat_mul  in  1  multiply-complete from array
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job completion
- error  out  1  sticky timeout flag; cleared by reset or cmd_start

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, beat and row counters clear, delay line clears. A reset mid-job discards any partial row with no write.
- FSM states: IDLE, LOAD_A, LOAD_B, DRAIN, RUN, FINISH.
  - IDLE: in_ready=0. cmd_start moves to LOAD_A and clears error.
  - LOAD_A / LOAD_B: in_ready=1 and enable_writing_to_mem=1.
  - cmd_start is ignored while busy.
- Packing:
  - Beat k (0..7) of a row goes to bits [k*HOST_W +: HOST_W] of the pack register.
  - The beat counter wraps 7->0. Each wrap completes a row.
- Write timing:
  - If a row completes on the accepting edge at cycle t, addr_pi = row index (0..31) during t+1.
  - data_pi = that row and exactly one of we_a/we_b are high for one cycle at t+1+WE_DELAY.
  - Implemented as a WE_DELAY-deep shift line carrying {row data, sel_a, sel_b, valid}.
  - Back-to-back rows are allowed, since a new row completes at most every 8 cycles. in_ready never drops during LOAD.
- Row counter: increments per completed row. Completing row 31 in LOAD_A moves to LOAD_B with the row counter reset to 0. Completing row 31 in LOAD_B moves to DRAIN.
- DRAIN:
  - in_ready=0 from the cycle after the last beat.
  - enable_writing_to_mem stays 1 until the final we_b has issued, then the block waits one further cycle and enters RUN.
- RUN:
  - enable_writing_to_mem=0 and start_mat_mul=1.
  - A cycle counter increments each cycle.
  - done_mat_mul sampled high moves to FINISH.
  - If the counter reaches RUN_TIMEOUT first: set error, go to FINISH.
- FINISH: start_mat_mul=0, done=1 for exactly one cycle, then IDLE.
- Invariants:
  - we_a and we_b are never both high.
  - we_* is never high outside LOAD/DRAIN.
  - addr_pi holds its last value between writes.

Decomposition:
- Shared package matmul_pkg holds:
  - the DWIDTH, AWIDTH, MAT_SIZE and HOST_W constants
  - the FSM state encoding (3-bit)
  - the derived BEATS_PER_ROW and ROW_W.
- One natural sub-module: row_packer (beat counter plus shift/pack register, emits row_valid and row_data).

Test Plan:
- Full job, in_valid always 1: cmd_start, 512 beats where beat n = n. Expect:
  - 64 write pulses.
  - Row 0 of A: data_pi[31:0]=0, [63:32]=1.
  - we_a at addr 0..31, then we_b at addr 0..31.
  - Each we lags its addr_pi by exactly 2 cycles.
  - start_mat_mul then rises; done_mat_mul forced at 50 cycles gives done pulse 1 cycle later and busy=0.
- Bursty host (in_valid random 50%): expect identical RAM contents to the first test; no write while a row is partial.
- Reset asserted after 3 beats of A row 5: expect no we_a for row 5, all outputs 0 next cycle, and a subsequent full job loading correctly.
- cmd_start pulsed during LOAD_B and during RUN: expect no effect; row counts and addresses unchanged.
- done_mat_mul withheld, RUN_TIMEOUT set to 100: expect error=1 and done pulse at RUN cycle 100; the next cmd_start clears error.
- A-to-B boundary: last beat of A row 31 followed immediately by the first beats of B. Expect:
  - we_a at addr 31, and the next write is we_b at addr 0 eight cycles later.
  - No overlap between we_a and we_b.
